// File: rtl/cnt_dly_measure.sv
`default_nettype none
// ============================================================================
// Module   : cnt_dly_measure
// Brief    : Closed-loop capture timer: cycles from a selected i_ref edge to
//            the next i_dut transition, delivered on a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module cnt_dly_measure #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_CNT     = 2**CNT_W - 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [1:0]       i_edge_sel,
    input  logic             i_ref,
    input  logic             i_dut,
    output logic             o_busy,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_delay,
    output logic             o_timeout,
    output logic             o_overrun,
    input  logic             i_clear_overrun
);

    localparam logic [1:0]       c_st_idle     = 2'd0;
    localparam logic [1:0]       c_st_wait_ref = 2'd1;
    localparam logic [1:0]       c_st_measure  = 2'd2;
    localparam logic [CNT_W-1:0] c_max_m1      = CNT_W'(MAX_CNT - 1);

    logic [SYNC_STAGES-1:0] r_ref_sync;
    logic [SYNC_STAGES-1:0] r_dut_sync;
    logic                   r_ref_hist;
    logic                   r_dut_hist;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;

    logic             w_ref_cur;
    logic             w_dut_cur;
    logic             w_ref_ev;
    logic             w_dut_ev;
    logic             w_emit;
    logic [CNT_W-1:0] w_emit_delay;
    logic             w_emit_timeout;

    // Identical depth on both paths, so synchronizer latency cancels out.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ref_sync <= '0;
            r_dut_sync <= '0;
            r_ref_hist <= 1'b0;
            r_dut_hist <= 1'b0;
        end else begin
            r_ref_sync <= {r_ref_sync[SYNC_STAGES-2:0], i_ref};
            r_dut_sync <= {r_dut_sync[SYNC_STAGES-2:0], i_dut};
            r_ref_hist <= r_ref_sync[SYNC_STAGES-1];
            r_dut_hist <= r_dut_sync[SYNC_STAGES-1];
        end
    end

    assign w_ref_cur = r_ref_sync[SYNC_STAGES-1];
    assign w_dut_cur = r_dut_sync[SYNC_STAGES-1];
    assign w_dut_ev  = w_dut_cur ^ r_dut_hist;

    always_comb begin
        w_ref_ev = 1'b0;
        case (i_edge_sel)
            2'd0:    w_ref_ev =  w_ref_cur & ~r_ref_hist;
            2'd1:    w_ref_ev = ~w_ref_cur &  r_ref_hist;
            2'd2:    w_ref_ev =  w_ref_cur ^  r_ref_hist;
            default: w_ref_ev = 1'b0;
        endcase
    end

    always_comb begin
        w_emit         = 1'b0;
        w_emit_delay   = '0;
        w_emit_timeout = 1'b0;
        if (i_enable) begin
            if (r_state == c_st_wait_ref && w_ref_ev && w_dut_ev) begin
                w_emit = 1'b1;
            end else if (r_state == c_st_measure) begin
                // r_cnt holds elapsed-1, so the result is r_cnt+1 (<= MAX_CNT).
                if (w_dut_ev || r_cnt == c_max_m1) begin
                    w_emit         = 1'b1;
                    w_emit_delay   = r_cnt + 1'b1;
                    w_emit_timeout = ~w_dut_ev;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else if (!i_enable) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: r_state <= c_st_wait_ref;
                c_st_wait_ref: begin
                    if (w_ref_ev && !w_dut_ev) begin
                        r_cnt   <= '0;
                        r_state <= c_st_measure;
                    end
                end
                c_st_measure: begin
                    if (w_emit) r_state <= c_st_wait_ref;
                    else        r_cnt   <= r_cnt + 1'b1;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign o_busy = (r_state == c_st_measure);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid   <= 1'b0;
            o_delay   <= '0;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (w_emit && (!o_valid || i_ready)) begin
                o_valid   <= 1'b1;
                o_delay   <= w_emit_delay;
                o_timeout <= w_emit_timeout;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
            // Set wins over clear when both occur in the same cycle.
            if (w_emit && o_valid && !i_ready) o_overrun <= 1'b1;
            else if (i_clear_overrun)          o_overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnt_dly_measure.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_dly_measure
// Brief    : Scoreboard bench for cnt_dly_measure (MAX_CNT=10, SYNC_STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_dly_measure;

    localparam int CNT_W = 16;
    localparam int MAXC  = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [1:0]       edge_sel = 2'd0;
    logic             ref_in = 1'b0;
    logic             dut_in = 1'b0;
    logic             ready = 1'b1;
    logic             clear_ovr = 1'b0;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] delay;
    logic             timeout;
    logic             overrun;

    int checks = 0;
    int errors = 0;
    logic [CNT_W:0] expq[$];

    cnt_dly_measure #(.CNT_W(CNT_W), .SYNC_STAGES(2), .MAX_CNT(MAXC)) u_dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_enable        (enable),
        .i_edge_sel      (edge_sel),
        .i_ref           (ref_in),
        .i_dut           (dut_in),
        .o_busy          (busy),
        .o_valid         (valid),
        .i_ready         (ready),
        .o_delay         (delay),
        .o_timeout       (timeout),
        .o_overrun       (overrun),
        .i_clear_overrun (clear_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input bit t);
        expq.push_back({t, CNT_W'(d)});
    endtask

    task automatic count_busy(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every accepted result is popped and compared.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got delay=%0d timeout=%0d expected none",
                         delay, timeout);
            end else begin
                logic [CNT_W:0] e;
                e = expq.pop_front();
                if ({timeout, delay} !== e) begin
                    errors++;
                    $display("FAIL result: got delay=%0d timeout=%0d expected delay=%0d timeout=%0d",
                             delay, timeout, e[CNT_W-1:0], e[CNT_W]);
                end
            end
        end
    end

    initial begin
        int bc;
        tick(3);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_delay", int'(delay), 0);
        chk("reset_timeout", int'(timeout), 0);
        chk("reset_overrun", int'(overrun), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        enable = 1'b1;
        tick(5);

        // Rising mode, delay 5
        push(5, 0);
        ref_in = 1'b1;
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) dut_in = ~dut_in;
            @(negedge clk);
            if (busy) bc++;
            @(posedge clk);
            #1;
        end
        chk("busy_cycles_d5", bc, 5);
        ref_in = 1'b0; tick(5);

        // Coincident edges
        push(0, 0);
        ref_in = 1'b1; dut_in = ~dut_in;
        count_busy(8, bc);
        chk("busy_coincident", bc, 0);
        ref_in = 1'b0; tick(5);

        // dut edge in the MAX_CNT cycle: normal result
        push(MAXC, 0);
        ref_in = 1'b1; tick(MAXC); dut_in = ~dut_in; tick(6);
        ref_in = 1'b0; tick(4);

        // Timeout, then a stray dut toggle produces nothing
        push(MAXC, 1);
        ref_in = 1'b1; tick(16); dut_in = ~dut_in; tick(10);
        ref_in = 1'b0; tick(4);

        // Backpressure: 3 held, 7 dropped
        ready = 1'b0;
        push(3, 0);
        ref_in = 1'b1; tick(3); dut_in = ~dut_in; tick(4);
        ref_in = 1'b0; tick(4);
        ref_in = 1'b1; tick(7); dut_in = ~dut_in; tick(6);
        @(negedge clk);
        chk("bp_valid", int'(valid), 1);
        chk("bp_delay_held", int'(delay), 3);
        chk("bp_overrun", int'(overrun), 1);
        @(posedge clk); #1;
        ready = 1'b1;
        tick(1);
        @(negedge clk);
        chk("bp_valid_drop", int'(valid), 0);
        @(posedge clk); #1;
        clear_ovr = 1'b1; tick(1); clear_ovr = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", int'(overrun), 0);
        @(posedge clk); #1;
        ref_in = 1'b0; tick(4);

        // Falling mode
        edge_sel = 2'd1;
        ref_in = 1'b1;
        count_busy(8, bc);
        chk("falling_ignores_rise", bc, 0);
        push(4, 0);
        ref_in = 1'b0; tick(4); dut_in = ~dut_in; tick(6);

        // Both edges
        edge_sel = 2'd2;
        push(2, 0);
        ref_in = 1'b1; tick(2); dut_in = ~dut_in; tick(5);
        push(6, 0);
        ref_in = 1'b0; tick(6); dut_in = ~dut_in; tick(6);

        // No reference edge
        edge_sel = 2'd3;
        ref_in = 1'b1; tick(2); dut_in = ~dut_in;
        count_busy(8, bc);
        ref_in = 1'b0; tick(2); dut_in = ~dut_in; tick(6);
        chk("none_mode_busy", bc, 0);

        // Disable two cycles into MEASURE
        edge_sel = 2'd0;
        ref_in = 1'b1; tick(5);
        @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        @(posedge clk); #1;
        enable = 1'b0;
        tick(1);
        @(negedge clk);
        chk("abort_busy_after", int'(busy), 0);
        @(posedge clk); #1;
        dut_in = ~dut_in; tick(6);
        enable = 1'b1; tick(3);
        ref_in = 1'b0; tick(4);

        // Reset mid-MEASURE with a held result
        ready = 1'b0;
        ref_in = 1'b1; tick(2); dut_in = ~dut_in; tick(6);
        ref_in = 1'b0; tick(4);
        ref_in = 1'b1; tick(5);
        @(negedge clk);
        chk("pre_reset_valid", int'(valid), 1);
        chk("pre_reset_busy", int'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b1; ref_in = 1'b0; dut_in = 1'b0;
        tick(1);
        @(negedge clk);
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_valid", int'(valid), 0);
        chk("mid_reset_delay", int'(delay), 0);
        chk("mid_reset_timeout", int'(timeout), 0);
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b1;
        tick(12);

        for (int i = 0; i < 200 && expq.size() != 0; i++) tick(1);
        chk("scoreboard_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
